// File: rtl/design_1_pkg.sv
// Shared types and constants for the switch/LED/UART board wrapper.
package design_1_pkg;

  // Default system clock and UART bit rate
  localparam int CLK_HZ_DEF = 100_000_000;
  localparam int BAUD_DEF   = 115_200;

  // ASCII constants used by the message sequencer and the RX hex decoder
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Nibble to uppercase ASCII hex digit
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10) return ASCII_ZERO + {4'h0, n};
    else           return ASCII_UPPER_A + {4'h0, n - 4'd10};
  endfunction

  // ASCII hex digit to {valid, nibble}; valid = 0 for any other byte
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= ASCII_ZERO && c <= ASCII_ZERO + 8'd9)
      return {1'b1, c[3:0]};
    else if (c >= ASCII_UPPER_A && c <= ASCII_UPPER_A + 8'd5)
      return {1'b1, c[3:0] + 4'd9};
    else if (c >= ASCII_LOWER_A && c <= ASCII_LOWER_A + 8'd5)
      return {1'b1, c[3:0] + 4'd9};
    else
      return 5'd0;
  endfunction

endpackage

// File: rtl/design_1_if.sv
// Byte-level link between the message sequencer and the UART core.
interface design_1_if;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;

  modport master (output tx_valid, tx_data, input tx_ready, tx_busy, rx_valid, rx_data);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx_busy, rx_valid, rx_data);
endinterface

// File: rtl/design_1_uart_8n1.sv
// 8N1 UART core: baud counters, TX FSM and RX FSM. rxd_i must already be synchronized.
module uart_8n1
  import design_1_pkg::*;
#(
  parameter int BIT_CYC = CLK_HZ_DEF / BAUD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd_i,
  output logic txd_o,
  design_1_if.slave bus
);

  localparam int CNT_W = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

  tx_state_e        tx_state_q, tx_state_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;
  logic             tx_ready_c;

  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rxd_prev_q;

  // TX: ready in IDLE and on the last STOP cycle so back-to-back bytes have no gap
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    txd_d      = txd_q;
    tx_ready_c = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_ready_c = 1'b1;
        txd_d      = 1'b1;
        if (bus.tx_valid) begin
          tx_sh_d    = bus.tx_data;
          txd_d      = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_sh_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_ready_c = 1'b1;
          tx_cnt_d   = '0;
          if (bus.tx_valid) begin
            tx_sh_d    = bus.tx_data;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // RX: falling edge starts a frame, bits sampled mid-period, bad stop bit drops the byte
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_valid_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_i) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rxd_i ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rxd_i, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_valid_d = rxd_i;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // State registers; reset aborts any frame and parks txd high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_valid_q <= 1'b0;
      rxd_prev_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      txd_q      <= txd_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_valid_q <= rx_valid_d;
      rxd_prev_q <= rxd_i;
    end
  end

  assign txd_o        = txd_q;
  assign bus.tx_ready = tx_ready_c;
  assign bus.tx_busy  = (tx_state_q != TX_IDLE);
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_sh_q;

endmodule

// File: rtl/design_1_wrapper.sv
// Board top: input synchronizers, button debounce, LED register and hex message sequencer.
module design_1_wrapper
  import design_1_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int DEB_CYCLES = 100
) (
  input  logic        sys_clock,
  input  logic        reset,
  input  logic [15:0] dip_switches_16bits_tri_i,
  input  logic [3:0]  push_buttons_4bits_tri_i,
  output logic [15:0] led_16bits_tri_o,
  input  logic        usb_uart_rxd,
  output logic        usb_uart_txd
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [15:0]      sw_s1_q, sw_s2_q;
  logic [3:0]       btn_s1_q, btn_s2_q;
  logic             rxd_s1_q, rxd_s2_q;

  logic [3:0]       deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q [4];
  logic [DEB_W-1:0] deb_cnt_d [4];
  logic [1:0]       deb_prev_q;
  logic             b0_rise, b1_rise;

  logic [15:0]      led_q, led_d;
  logic             msg_busy_q, msg_busy_d;
  logic [2:0]       msg_idx_q, msg_idx_d;
  logic [15:0]      msg_val_q, msg_val_d;
  logic [7:0]       msg_char;
  logic [4:0]       rx_hex;

  design_1_if uart_bus ();

  // Two-flop synchronizers; rxd idles high so its chain resets to 1
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
    end else begin
      sw_s1_q  <= dip_switches_16bits_tri_i;
      sw_s2_q  <= sw_s1_q;
      btn_s1_q <= push_buttons_4bits_tri_i;
      btn_s2_q <= btn_s1_q;
      rxd_s1_q <= usb_uart_rxd;
      rxd_s2_q <= rxd_s1_q;
    end
  end

  // Debounce: accepted level flips after DEB_CYCLES consecutive differing samples
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (btn_s2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) deb_d[i] = btn_s2_q[i];
        else                          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  assign b0_rise = deb_q[0] & ~deb_prev_q[0];
  assign b1_rise = deb_q[1] & ~deb_prev_q[1];
  assign rx_hex  = hex_decode(uart_bus.rx_data);

  // LED register: button-0 load beats button-1 clear beats RX nibble shift
  always_comb begin
    led_d = led_q;
    if (b0_rise)                                 led_d = sw_s2_q;
    else if (b1_rise)                            led_d = '0;
    else if (uart_bus.rx_valid && rx_hex[4])     led_d = {led_q[11:0], rx_hex[3:0]};
  end

  // Message sequencer: a button-0 edge while busy is dropped, not queued
  always_comb begin
    msg_busy_d = msg_busy_q;
    msg_idx_d  = msg_idx_q;
    msg_val_d  = msg_val_q;
    if (msg_busy_q) begin
      if (uart_bus.tx_ready) begin
        if (msg_idx_q == 3'd5) msg_busy_d = 1'b0;
        else                   msg_idx_d  = msg_idx_q + 1'b1;
      end
    end else if (b0_rise && !uart_bus.tx_busy) begin
      msg_busy_d = 1'b1;
      msg_idx_d  = '0;
      msg_val_d  = sw_s2_q;
    end
  end

  // Current message byte: four hex digits MSN first, then CR LF
  always_comb begin
    case (msg_idx_q)
      3'd0:    msg_char = nibble_to_ascii(msg_val_q[15:12]);
      3'd1:    msg_char = nibble_to_ascii(msg_val_q[11:8]);
      3'd2:    msg_char = nibble_to_ascii(msg_val_q[7:4]);
      3'd3:    msg_char = nibble_to_ascii(msg_val_q[3:0]);
      3'd4:    msg_char = ASCII_CR;
      default: msg_char = ASCII_LF;
    endcase
  end

  // Debounce, LED and sequencer state
  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
      led_q      <= '0;
      msg_busy_q <= 1'b0;
      msg_idx_q  <= '0;
      msg_val_q  <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q[1:0];
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      led_q      <= led_d;
      msg_busy_q <= msg_busy_d;
      msg_idx_q  <= msg_idx_d;
      msg_val_q  <= msg_val_d;
    end
  end

  assign uart_bus.tx_valid = msg_busy_q;
  assign uart_bus.tx_data  = msg_char;
  assign led_16bits_tri_o  = led_q;

  uart_8n1 #(
    .BIT_CYC (CLK_HZ / BAUD)
  ) u_uart (
    .clk   (sys_clock),
    .rst_n (reset),
    .rxd_i (rxd_s2_q),
    .txd_o (usb_uart_txd),
    .bus   (uart_bus.slave)
  );

endmodule

// File: tb/tb_design_1_wrapper.sv
// Scoreboard bench for design_1_wrapper: expected TX bytes are queued at stimulus time.
module tb_design_1_wrapper;

  localparam int BIT = 16;

  logic        sys_clock = 1'b0;
  logic        reset     = 1'b0;
  logic [15:0] sw        = 16'h0000;
  logic [3:0]  btn       = 4'h0;
  logic        rxd       = 1'b1;
  logic [15:0] led;
  logic        txd;

  logic [7:0]  exp_q[$];
  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          tx_seen = 0;

  always #5 sys_clock = ~sys_clock;

  design_1_wrapper #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .DEB_CYCLES (100)
  ) dut (
    .sys_clock                 (sys_clock),
    .reset                     (reset),
    .dip_switches_16bits_tri_i (sw),
    .push_buttons_4bits_tri_i  (btn),
    .led_16bits_tri_o          (led),
    .usb_uart_rxd              (rxd),
    .usb_uart_txd              (txd)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clock);
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  task automatic push_msg(input logic [15:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(hex_char(v[15 - 4*i -: 4]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    cycles(hold);
    btn[idx] = 1'b0;
    cycles(150);
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() != 0 && t < limit) begin
      cycles(1);
      t++;
    end
    check("tx_drain", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    cycles(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      cycles(BIT);
    end
    rxd = stop_bit;
    cycles(BIT);
    rxd = 1'b1;
    cycles(2 * BIT);
  endtask

  // TX line monitor: decodes 8N1 frames and checks them against the scoreboard
  initial begin : tx_mon
    logic [7:0] b;
    logic       stop_b;
    b = 8'h00;
    forever begin
      @(negedge sys_clock);
      if (reset && txd === 1'b0) begin
        repeat (BIT / 2) @(negedge sys_clock);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge sys_clock);
          b[i] = txd;
        end
        repeat (BIT) @(negedge sys_clock);
        stop_b = txd;
        tx_seen++;
        check("tx_stop", {15'd0, stop_b}, 16'd1);
        if (exp_q.size() == 0) check("tx_extra_byte", {8'd0, b}, 16'hFFFF);
        else                   check("tx_byte", {8'd0, b}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin : main
    // Reset held: LEDs clear and txd idle
    cycles(5);
    check("rst_led", led, 16'h0000);
    check("rst_txd", {15'd0, txd}, 16'd1);
    cycles(5);
    check("rst_txd_late", {15'd0, txd}, 16'd1);
    reset = 1'b1;
    cycles(3);
    check("post_rst_led", led, 16'h0000);
    check("post_rst_txd", {15'd0, txd}, 16'd1);

    // First press: 0x1234, held 1000 cycles
    sw = 16'h1234;
    push_msg(16'h1234);
    btn[0] = 1'b1;
    cycles(50);
    check("led_before_debounce", led, 16'h0000);
    cycles(950);
    check("led_1234", led, 16'h1234);
    btn[0] = 1'b0;
    cycles(150);
    wait_drain(3000);

    // Second press after message completes
    sw = 16'h5678;
    push_msg(16'h5678);
    press(0, 200);
    check("led_5678", led, 16'h5678);
    wait_drain(3000);

    // Press during an active message: LEDs follow, TX dropped
    sw = 16'h9ABC;
    push_msg(16'h9ABC);
    press(0, 200);
    check("led_9abc", led, 16'h9ABC);
    sw = 16'h0DEF;
    press(0, 200);
    check("led_0def_busy", led, 16'h0DEF);
    wait_drain(3000);
    cycles(1200);
    check("tx_count_after_busy", 16'(tx_seen), 16'd18);

    // Button 1 clears
    press(1, 200);
    check("led_clear", led, 16'h0000);

    // RX nibble shifts, non-hex ignored, framing error dropped
    uart_send(8'h61, 1'b1);
    check("rx_a", led, 16'h000A);
    uart_send(8'h42, 1'b1);
    check("rx_B", led, 16'h00AB);
    uart_send(8'h78, 1'b1);
    check("rx_x_ignored", led, 16'h00AB);
    uart_send(8'h33, 1'b1);
    check("rx_3", led, 16'h0AB3);
    uart_send(8'h37, 1'b0);
    check("rx_bad_stop", led, 16'h0AB3);

    // Short bounce on button 0 and presses on buttons 2/3 do nothing
    sw = 16'hFFFF;
    btn[0] = 1'b1;
    cycles(50);
    btn[0] = 1'b0;
    cycles(300);
    check("bounce_led", led, 16'h0AB3);
    press(2, 200);
    press(3, 200);
    check("btn23_led", led, 16'h0AB3);
    cycles(400);
    check("tx_count_final", 16'(tx_seen), 16'd18);
    check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
